// File: rtl/arm_sc_control_unit.sv
// arm_sc_control_unit
//   Control unit for the single-cycle ARM datapath. Decodes Instr into
//   datapath control strobes, holds the architectural NZCV flags register and
//   evaluates the condition field. A failed condition suppresses PCSrc,
//   RegWrite, MemWrite and any flag update.
//
// Parameters
//   FLAGS_RST  NZCV value loaded on reset
//   PERF_W     width of the optional performance counters
//
// Ports
//   clk       rising-edge clock
//   Reset     asynchronous, active-low reset (clears Flags to FLAGS_RST)
//   Instr     current instruction
//   ALUFlags  datapath ALU flags {N,Z,C,V}
//   PCSrc, MemtoReg, ALUSrc, RegWrite, MemWrite, ALUCtrl, RegSrc, ImmSrc
//             combinational datapath controls
//   Flags     registered NZCV
//
// Optional build macro CTRL_PERF_CNT_EN adds InstrCnt (edges out of reset)
// and SquashCnt (instructions squashed or undefined), both wrapping.

module arm_sc_control_unit #(
    parameter logic [3:0]  FLAGS_RST = 4'b0000,
    parameter int unsigned PERF_W    = 32
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [31:0]       Instr,
    input  logic [3:0]        ALUFlags,
    output logic              PCSrc,
    output logic              MemtoReg,
    output logic              ALUSrc,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic [1:0]        ALUCtrl,
    output logic [1:0]        RegSrc,
    output logic [1:0]        ImmSrc,
`ifdef CTRL_PERF_CNT_EN
    output logic [PERF_W-1:0] InstrCnt,
    output logic [PERF_W-1:0] SquashCnt,
`endif
    output logic [3:0]        Flags
);

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_UND = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_t;

    logic [3:0] cond;
    op_t        op;
    logic [5:0] funct;
    logic [3:0] rd;

    assign cond  = Instr[31:28];
    assign op    = op_t'(Instr[27:26]);
    assign funct = Instr[25:20];
    assign rd    = Instr[15:12];

    // Register/immediate fields the control unit never looks at.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

    logic       branch, regw_raw, memw, aluop, cmd_undef, regw;
    logic [1:0] flagw;
    alu_t       alu_ctrl;
    logic       condex, pcs, undef_instr;

    // Main decoder
    always_comb begin
        branch   = 1'b0;
        regw_raw = 1'b0;
        memw     = 1'b0;
        aluop    = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        RegSrc   = 2'b00;
        ImmSrc   = 2'b00;
        case (op)
            OP_DP: begin
                regw_raw = 1'b1;
                ALUSrc   = funct[5];
                aluop    = 1'b1;
            end
            OP_MEM: begin
                ALUSrc = 1'b1;
                ImmSrc = 2'b01;
                if (funct[0]) begin
                    regw_raw = 1'b1;
                    MemtoReg = 1'b1;
                end else begin
                    memw   = 1'b1;
                    RegSrc = 2'b10;
                end
            end
            OP_BR: begin
                branch = 1'b1;
                ALUSrc = 1'b1;
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: ;
        endcase
    end

    // ALU decoder; an unknown DP command drops its register and flag writes
    always_comb begin
        alu_ctrl  = ALU_ADD;
        cmd_undef = 1'b0;
        flagw     = 2'b00;
        if (aluop) begin
            case (funct[4:1])
                4'b0100: alu_ctrl = ALU_ADD;
                4'b0010: alu_ctrl = ALU_SUB;
                4'b0000: alu_ctrl = ALU_AND;
                4'b1100: alu_ctrl = ALU_ORR;
                default: cmd_undef = 1'b1;
            endcase
            if (!cmd_undef) begin
                flagw[1] = funct[0];
                flagw[0] = funct[0] & ((alu_ctrl == ALU_ADD) || (alu_ctrl == ALU_SUB));
            end
        end
    end

    assign ALUCtrl     = alu_ctrl;
    assign regw        = regw_raw & ~cmd_undef;
    assign pcs         = branch | (regw & (rd == 4'hF));
    assign undef_instr = (op == OP_UND) | cmd_undef;

    // Condition check against the registered flags
    always_comb begin
        case (cond)
            4'h0:    condex = Flags[2];
            4'h1:    condex = ~Flags[2];
            4'h2:    condex = Flags[1];
            4'h3:    condex = ~Flags[1];
            4'h4:    condex = Flags[3];
            4'h5:    condex = ~Flags[3];
            4'h6:    condex = Flags[0];
            4'h7:    condex = ~Flags[0];
            4'h8:    condex = Flags[1] & ~Flags[2];
            4'h9:    condex = ~Flags[1] | Flags[2];
            4'hA:    condex = (Flags[3] == Flags[0]);
            4'hB:    condex = (Flags[3] != Flags[0]);
            4'hC:    condex = ~Flags[2] & (Flags[3] == Flags[0]);
            4'hD:    condex = Flags[2] | (Flags[3] != Flags[0]);
            4'hE:    condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign PCSrc    = pcs & condex;
    assign RegWrite = regw & condex;
    assign MemWrite = memw & condex;

    // NZ and CV halves update independently
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            Flags <= FLAGS_RST;
        end else begin
            if (flagw[1] & condex) Flags[3:2] <= ALUFlags[3:2];
            if (flagw[0] & condex) Flags[1:0] <= ALUFlags[1:0];
        end
    end

`ifdef CTRL_PERF_CNT_EN
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            InstrCnt  <= '0;
            SquashCnt <= '0;
        end else begin
            InstrCnt <= InstrCnt + PERF_W'(1);
            if (~condex | undef_instr) SquashCnt <= SquashCnt + PERF_W'(1);
        end
    end
`else
    logic unused_undef;
    assign unused_undef = undef_instr;
`endif

endmodule

// File: tb/tb_arm_sc_control_unit.sv
module tb_arm_sc_control_unit;

    localparam logic [3:0] FRST = 4'b0000;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Instr = 32'hE0802003;
    logic [3:0]  ALUFlags = 4'b0000;
    logic        PCSrc, MemtoReg, ALUSrc, RegWrite, MemWrite;
    logic [1:0]  ALUCtrl, RegSrc, ImmSrc;
    logic [3:0]  Flags;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] InstrCnt, SquashCnt;
`endif

    int total = 0;
    int bad = 0;

    arm_sc_control_unit #(.FLAGS_RST(FRST), .PERF_W(32)) dut (
        .clk(clk), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCSrc(PCSrc), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl),
        .RegSrc(RegSrc), .ImmSrc(ImmSrc),
`ifdef CTRL_PERF_CNT_EN
        .InstrCnt(InstrCnt), .SquashCnt(SquashCnt),
`endif
        .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcsrc, memtoreg, alusrc, regwrite, memwrite;
        logic [1:0] aluctrl, regsrc, immsrc;
    } out_t;

    out_t obs;
    assign obs = {PCSrc, MemtoReg, ALUSrc, RegWrite, MemWrite, ALUCtrl, RegSrc, ImmSrc};

    // ---------------- reference model ----------------
    function automatic logic cond_pass(input logic [3:0] cnd, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cnd)
            0: return z;           1: return !z;
            2: return c;           3: return !c;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return c && !z;     9: return !c || z;
            10: return n == v;     11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // index of a DP command in the supported list ADD,SUB,AND,ORR; -1 if unknown
    function automatic int dp_index(input logic [3:0] cmd);
        logic [3:0] cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
        for (int i = 0; i < 4; i++) if (cmds[i] == cmd) return i;
        return -1;
    endfunction

    function automatic out_t model_out(input logic [31:0] ins, input logic [3:0] f);
        out_t e = '0;
        logic pass = cond_pass(ins[31:28], f);
        logic [5:0] fn = ins[25:20];
        logic rd15 = (ins[15:12] == 4'hF);
        int k;
        case (ins[27:26])
            2'd0: begin
                k = dp_index(fn[4:1]);
                e.alusrc = fn[5];
                if (k >= 0) begin
                    e.aluctrl  = 2'(k);
                    e.regwrite = pass;
                    e.pcsrc    = pass && rd15;
                end
            end
            2'd1: begin
                e.alusrc = 1; e.immsrc = 2'd1;
                if (fn[0]) begin
                    e.regwrite = pass; e.memtoreg = 1; e.pcsrc = pass && rd15;
                end else begin
                    e.memwrite = pass; e.regsrc = 2'd2;
                end
            end
            2'd2: begin
                e.pcsrc = pass; e.alusrc = 1; e.immsrc = 2'd2; e.regsrc = 2'd1;
            end
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] model_flags(input logic [31:0] ins, input logic [3:0] f,
                                               input logic [3:0] af);
        logic [3:0] nf = f;
        int k = dp_index(ins[24:21]);
        if (ins[27:26] == 2'd0 && k >= 0 && ins[20] && cond_pass(ins[31:28], f)) begin
            nf[3:2] = af[3:2];
            if (k < 2) nf[1:0] = af[1:0];
        end
        return nf;
    endfunction

    function automatic logic model_squash(input logic [31:0] ins, input logic [3:0] f);
        if (!cond_pass(ins[31:28], f)) return 1'b1;
        if (ins[27:26] == 2'd3) return 1'b1;
        if (ins[27:26] == 2'd0 && dp_index(ins[24:21]) < 0) return 1'b1;
        return 1'b0;
    endfunction

    logic [3:0]  mflags = FRST;
    logic [31:0] m_icnt = 0, m_sqcnt = 0;

    always @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            mflags  <= FRST;
            m_icnt  <= 0;
            m_sqcnt <= 0;
        end else begin
            mflags  <= model_flags(Instr, mflags, ALUFlags);
            m_icnt  <= m_icnt + 1;
            m_sqcnt <= m_sqcnt + 32'(model_squash(Instr, mflags));
        end
    end

    // ---------------- tests ----------------
    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b0;
        #2;
        @(negedge clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        out_t e;
        Reset = 1'b0; Instr = 32'hE0802003; ALUFlags = 4'b1111;
        @(negedge clk); #1;
        e = '0; e.regwrite = 1;
        total++;
        if (obs !== e) begin bad++; $display("FAIL reset_add_outputs: got %h want %h", obs, e); end
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", Flags); end
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags_hold: got %b want 0000", Flags); end
        @(negedge clk);
        Reset = 1'b1;
    endtask

    task automatic test_beq_taken();
        out_t e;
        @(negedge clk); Instr = 32'hE0500000; ALUFlags = 4'b0110;
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b0110) begin bad++; $display("FAIL subs_flags: got %b want 0110", Flags); end
        @(negedge clk); Instr = 32'h0A000002; ALUFlags = 4'b0000; #1;
        e = '0; e.pcsrc = 1; e.alusrc = 1; e.immsrc = 2'b10; e.regsrc = 2'b01;
        total++;
        if (obs !== e) begin bad++; $display("FAIL beq_taken: got %h want %h", obs, e); end
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b0110) begin bad++; $display("FAIL beq_flags_hold: got %b want 0110", Flags); end
    endtask

    task automatic test_beq_squashed();
        out_t e;
        do_reset();
        Instr = 32'h0A000002; ALUFlags = 4'b1111; #1;
        e = '0; e.alusrc = 1; e.immsrc = 2'b10; e.regsrc = 2'b01;
        total++;
        if (obs !== e) begin bad++; $display("FAIL beq_squash: got %h want %h", obs, e); end
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL beq_squash_flags: got %b want 0000", Flags); end
`ifdef CTRL_PERF_CNT_EN
        total++;
        if (SquashCnt !== 32'd1) begin bad++; $display("FAIL squash_cnt: got %0d want 1", SquashCnt); end
        total++;
        if (InstrCnt !== 32'd1) begin bad++; $display("FAIL instr_cnt: got %0d want 1", InstrCnt); end
`endif
    endtask

    task automatic test_mem();
        out_t e;
        @(negedge clk); Instr = 32'hE5801004; #1;
        e = '0; e.memwrite = 1; e.alusrc = 1; e.immsrc = 2'b01; e.regsrc = 2'b10;
        total++;
        if (obs !== e) begin bad++; $display("FAIL str: got %h want %h", obs, e); end
        @(negedge clk); Instr = 32'hE5901004; #1;
        e = '0; e.regwrite = 1; e.memtoreg = 1; e.alusrc = 1; e.immsrc = 2'b01;
        total++;
        if (obs !== e) begin bad++; $display("FAIL ldr: got %h want %h", obs, e); end
    endtask

    task automatic test_sequence();
        @(negedge clk); Instr = 32'hE0910002; ALUFlags = 4'b0011;
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b0011) begin bad++; $display("FAIL adds_flags: got %b want 0011", Flags); end
        @(negedge clk); Instr = 32'hE0110002; ALUFlags = 4'b1000;
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b1011) begin bad++; $display("FAIL ands_flags: got %b want 1011", Flags); end
        @(negedge clk); Instr = 32'hE08FF000; ALUFlags = 4'b0000; #1;
        total++;
        if ({PCSrc, RegWrite, MemWrite} !== 3'b110)
            begin bad++; $display("FAIL add_pc: got %b want 110", {PCSrc, RegWrite, MemWrite}); end
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b1011) begin bad++; $display("FAIL add_pc_flags: got %b want 1011", Flags); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); #2;
        Reset = 1'b0; #1;
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL async_reset: got %b want 0000", Flags); end
        Instr = 32'hE0910002; ALUFlags = 4'b1111;
        @(posedge clk); #1;
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_no_update: got %b want 0000", Flags); end
        @(negedge clk);
        Reset = 1'b1;
    endtask

    task automatic test_random(input int n);
        logic [31:0] ins;
        logic [3:0]  cmds [4] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100};
        out_t e;
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) != 0) ins[31:28] = 4'($urandom_range(0, 13));
            if (ins[27:26] == 2'd0 && $urandom_range(0, 4) != 0) ins[24:21] = cmds[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
            @(negedge clk);
            Instr = ins; ALUFlags = 4'($urandom);
            #1;
            e = model_out(ins, mflags);
            total++;
            if (obs !== e) begin
                bad++;
                if (errs++ < 10) $display("FAIL rand_out i=%0d instr=%h flags=%b: got %h want %h",
                                          i, ins, mflags, obs, e);
            end
            @(posedge clk); #1;
            total++;
            if (Flags !== mflags) begin
                bad++;
                if (errs++ < 10) $display("FAIL rand_flags i=%0d instr=%h: got %b want %b",
                                          i, ins, Flags, mflags);
            end
        end
`ifdef CTRL_PERF_CNT_EN
        total++;
        if (InstrCnt !== m_icnt) begin bad++; $display("FAIL rand_instr_cnt: got %0d want %0d", InstrCnt, m_icnt); end
        total++;
        if (SquashCnt !== m_sqcnt) begin bad++; $display("FAIL rand_squash_cnt: got %0d want %0d", SquashCnt, m_sqcnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_beq_taken();
        test_beq_squashed();
        test_mem();
        test_sequence();
        test_async_reset();
        test_random(300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
